// File: rtl/linreg_pkg.sv
// Shared constants for the linear-regression datapath: default widths, FSM state
// encoding and a sign-extension helper usable in constant and runtime contexts.
package linreg_pkg;

    localparam int LINREG_DATA_W = 8;
    localparam int LINREG_ADDR_W = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_BIAS  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Sign-extends the low w bits of v to 32 bits.
    function automatic logic signed [31:0] sext32(input logic [31:0] v, input int w);
        logic signed [31:0] t;
        t = $signed(v << (32 - w));
        return t >>> (32 - w);
    endfunction

endpackage

// File: rtl/linreg_smul.sv
// Combinational signed DATA_W x DATA_W multiplier producing a full-width product.
module linreg_smul
    import linreg_pkg::*;
#(
    parameter int DATA_W = LINREG_DATA_W
) (
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    output logic signed [2*DATA_W-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/linreg_dot_seq.sv
// Sequential dot product y = sum(w_i*x_i) + b over two read-only memories.
// Define LINREG_DOT_SAT_EN to saturate the result to OUT_W and expose sat_flag.
module linreg_dot_seq
    import linreg_pkg::*;
#(
    parameter int DATA_W  = LINREG_DATA_W,
    parameter int ADDR_W  = LINREG_ADDR_W,
    parameter int N_TERMS = 3,
    parameter int RD_LAT  = 1,
    parameter int ACC_W   = 20,
    parameter int OUT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] bias,
    output logic [OUT_W-1:0]  y,
    output logic              y_valid,
    input  logic              y_ready
`ifdef LINREG_DOT_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(N_TERMS - 1);
    localparam logic [1:0]       DRAIN_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 1) : 2'd0;
`ifdef LINREG_DOT_SAT_EN
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'(2**(OUT_W-1) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(2**(OUT_W-1)));
`endif

    logic [2:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [1:0]               drain_q, drain_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [OUT_W-1:0]  y_q, y_d;
    logic                     sat_q, sat_d;
    logic                     fetch;
    logic                     slot_vld;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [31:0]       bias_ext;
    logic signed [SUM_W-1:0]  sum_w;

    function automatic logic signed [OUT_W-1:0] conv_out(input logic signed [SUM_W-1:0] v);
`ifdef LINREG_DOT_SAT_EN
        if (v > OUT_MAX) return OUT_W'(OUT_MAX);
        if (v < OUT_MIN) return OUT_W'(OUT_MIN);
        return OUT_W'(v);
`else
        return OUT_W'(v);
`endif
    endfunction

    function automatic logic is_clamped(input logic signed [SUM_W-1:0] v);
`ifdef LINREG_DOT_SAT_EN
        return (v > OUT_MAX) || (v < OUT_MIN);
`else
        return (v != v);
`endif
    endfunction

    linreg_smul #(.DATA_W(DATA_W)) u_mul (
        .a_i ($signed(w_data)),
        .b_i ($signed(x_data)),
        .p_o (prod)
    );

    assign fetch = (state_q == ST_FETCH);

    // Slot tags: data for an address arrives RD_LAT cycles after it was issued.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign slot_vld = fetch;
        end else begin : g_latn
            logic [RD_LAT-1:0] tag_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) tag_q <= '0;
                else     tag_q <= RD_LAT'({tag_q, fetch});
            end
            assign slot_vld = tag_q[RD_LAT-1];
        end
    endgenerate

    assign bias_ext = sext32({{(32-DATA_W){1'b0}}, bias}, DATA_W);
    assign sum_w    = SUM_W'(acc_q) + SUM_W'(bias_ext);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        acc_d   = acc_q;
        y_d     = y_q;
        sat_d   = sat_q;
        if (slot_vld) acc_d = acc_q + ACC_W'(prod);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                    addr_d  = '0;
                    acc_d   = '0;
                end
            end
            ST_FETCH: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = (RD_LAT == 0) ? ST_BIAS : ST_DRAIN;
                    drain_d = '0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = ST_BIAS;
                else                       drain_d = drain_q + 1'b1;
            end
            ST_BIAS: begin
                y_d     = conv_out(sum_w);
                sat_d   = is_clamped(sum_w);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (y_ready) begin
                    state_d = ST_IDLE;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            drain_q <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign mem_rd  = fetch;
    assign w_addr  = addr_q;
    assign x_addr  = addr_q;
    assign y       = y_q;
    assign y_valid = (state_q == ST_DONE);
`ifdef LINREG_DOT_SAT_EN
    assign sat_flag = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_linreg_dot_seq.sv
// Self-checking bench for linreg_dot_seq: cycle-level reference model plus
// directed and randomized runs, and N_TERMS=16 sweeps at RD_LAT 0 and 2.
module tb_linreg_dot_seq;

    localparam int N = 3;
    localparam int L = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start, y_ready;
    logic signed [7:0] bias;
    logic              busy, mem_rd, y_valid;
    logic [3:0]        w_addr, x_addr;
    logic [7:0]        w_rd, x_rd;
    logic [15:0]       y;
    logic signed [7:0] wm [16];
    logic signed [7:0] xm [16];

    int errors = 0;
    int checks = 0;

    // Memories with one-cycle read latency
    always @(posedge clk) begin
        w_rd <= wm[w_addr];
        x_rd <= xm[x_addr];
    end

`ifdef LINREG_DOT_SAT_EN
    logic sat_flag, sat_a, sat_b;
`endif

    linreg_dot_seq dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .mem_rd(mem_rd),
        .w_addr(w_addr), .w_data(w_rd), .x_addr(x_addr), .x_data(x_rd),
        .bias(bias), .y(y), .y_valid(y_valid), .y_ready(y_ready)
`ifdef LINREG_DOT_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    // Sweep instances: w_i = 1, x_i = address
    logic        st_a, st_b, rdy_s;
    logic        busy_a, rd_a, yv_a, busy_b, rd_b, yv_b;
    logic [3:0]  wa_a, xa_a, wa_b, xa_b, ab1, ab2;
    logic [15:0] y_a, y_b;
    logic [7:0]  xd_a, xd_b;
    logic [7:0]  one8 = 8'd1;
    logic [7:0]  zero8 = 8'd0;
    assign xd_a = {4'd0, xa_a};
    always @(posedge clk) begin
        ab1 <= xa_b;
        ab2 <= ab1;
    end
    assign xd_b = {4'd0, ab2};

    linreg_dot_seq #(.N_TERMS(16), .RD_LAT(0)) dut_a (
        .clk(clk), .rst(rst), .start(st_a), .busy(busy_a), .mem_rd(rd_a),
        .w_addr(wa_a), .w_data(one8), .x_addr(xa_a), .x_data(xd_a),
        .bias(zero8), .y(y_a), .y_valid(yv_a), .y_ready(rdy_s)
`ifdef LINREG_DOT_SAT_EN
        , .sat_flag(sat_a)
`endif
    );

    linreg_dot_seq #(.N_TERMS(16), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(st_b), .busy(busy_b), .mem_rd(rd_b),
        .w_addr(wa_b), .w_data(one8), .x_addr(xa_b), .x_data(xd_b),
        .bias(zero8), .y(y_b), .y_valid(yv_b), .y_ready(rdy_s)
`ifdef LINREG_DOT_SAT_EN
        , .sat_flag(sat_b)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic over the memory contents
    function automatic logic [15:0] model_y();
        int s;
        s = int'(bias);
        for (int i = 0; i < N; i++) s += int'(wm[i]) * int'(xm[i]);
`ifdef LINREG_DOT_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return 16'(s);
    endfunction

    function automatic logic model_sat();
        int s;
        s = int'(bias);
        for (int i = 0; i < N; i++) s += int'(wm[i]) * int'(xm[i]);
        return (s > 32767) || (s < -32768);
    endfunction

    // Cycle-level model: phase 0 idle, 1 running (m_t cycles since start), 2 result held
    int          m_phase = 0;
    int          m_t = 0;
    logic        m_yv = 1'b0;
    logic        m_sat = 1'b0;
    logic [15:0] m_y = 16'd0;
    logic [3:0]  m_addr = 4'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_t <= 0; m_yv <= 1'b0; m_y <= 16'd0; m_addr <= 4'd0; m_sat <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1; m_t <= 0; m_addr <= 4'd0;
                end
                1: begin
                    m_t <= m_t + 1;
                    if (m_t + 1 < N) m_addr <= 4'(m_t + 1);
                    if (m_t + 1 == N + L + 1) begin
                        m_yv <= 1'b1; m_y <= model_y(); m_sat <= model_sat(); m_phase <= 2;
                    end
                end
                default: if (y_ready) begin
                    m_yv <= 1'b0; m_sat <= 1'b0; m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("y_valid", 32'(y_valid), 32'(m_yv));
        chk("y", 32'(y), 32'(m_y));
        chk("mem_rd", 32'(mem_rd), 32'(m_phase == 1 && m_t < N));
        chk("w_addr", 32'(w_addr), 32'(m_addr));
        chk("x_addr", 32'(x_addr), 32'(m_addr));
`ifdef LINREG_DOT_SAT_EN
        chk("sat_flag", 32'(sat_flag), 32'(m_sat));
`endif
    end

    int hs_cnt = 0;
    always @(posedge clk) if (y_valid && y_ready) hs_cnt <= hs_cnt + 1;

    task automatic set_mem(input int w0, w1, w2, x0, x1, x2, b);
        wm[0] = 8'(w0); wm[1] = 8'(w1); wm[2] = 8'(w2);
        xm[0] = 8'(x0); xm[1] = 8'(x1); xm[2] = 8'(x2);
        bias = 8'(b);
    endtask

    // Pulses start for one cycle and returns the cycles until y_valid is seen
    task automatic do_run(output int lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!y_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!y_valid) chk("run_timeout", 32'(y_valid), 32'd1);
    endtask

    task automatic sweep(input logic sel, input int exp_lat);
        int lat, k;
        logic v, r;
        logic [3:0] a;
        if (sel) st_b = 1'b1; else st_a = 1'b1;
        @(negedge clk);
        st_a = 1'b0; st_b = 1'b0;
        lat = 0; k = 0;
        forever begin
            r = sel ? rd_b : rd_a;
            a = sel ? wa_b : wa_a;
            v = sel ? yv_b : yv_a;
            if (r) begin
                chk("sweep_addr", 32'(a), 32'(k));
                k++;
            end
            if (v || lat >= 60) break;
            @(negedge clk);
            lat++;
        end
        chk("sweep_latency", 32'(lat), 32'(exp_lat));
        chk("sweep_addr_count", 32'(k), 32'd16);
        chk("sweep_y", 32'(sel ? y_b : y_a), 32'd120);
        chk("sweep_last_addr", 32'(sel ? wa_b : wa_a), 32'd15);
        @(negedge clk);
        chk("sweep_idle", 32'(sel ? busy_b : busy_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hs0;
        rst = 1'b1; start = 1'b0; y_ready = 1'b1; bias = '0;
        st_a = 1'b0; st_b = 1'b0; rdy_s = 1'b1;
        for (int i = 0; i < 16; i++) begin wm[i] = '0; xm[i] = '0; end
        repeat (2) @(negedge clk);
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_y_valid", 32'(y_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_rd", 32'(mem_rd), 32'd0);
        chk("reset_addr", 32'(w_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic result with address sequence
        set_mem(1, 2, 3, 4, 5, 6, 7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("basic_mem_rd", 32'(mem_rd), 32'd1);
            chk("basic_addr", 32'(w_addr), 32'(k));
            @(negedge clk);
        end
        lat = 3;
        while (!y_valid && lat < 50) begin @(negedge clk); lat++; end
        chk("basic_latency", 32'(lat), 32'd5);
        chk("basic_y", 32'(y), 32'h0027);
        @(negedge clk);
        chk("basic_after_hs", 32'(y_valid), 32'd0);

        // Negative extremes
        set_mem(-128, -128, -128, -128, -128, -128, 0);
        do_run(lat);
`ifdef LINREG_DOT_SAT_EN
        chk("wrap_y_sat", 32'(y), 32'h7FFF);
        chk("wrap_sat_flag", 32'(sat_flag), 32'd1);
`else
        chk("wrap_y", 32'(y), 32'hC000);
`endif
        @(negedge clk);

        // Backpressure: 20 - 15 - 28 - 2 = -25
        set_mem(10, -3, 7, 2, 5, -4, -2);
        y_ready = 1'b0;
        do_run(lat);
        for (int k = 0; k < 6; k++) begin
            chk("bp_valid", 32'(y_valid), 32'd1);
            chk("bp_y", 32'(y), 32'hFFE7);
            @(negedge clk);
        end
        y_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", 32'(y_valid), 32'd0);
        chk("bp_y_hold", 32'(y), 32'hFFE7);

        // Ignored starts during FETCH and DONE, including the handshake cycle
        set_mem(1, 1, 1, 1, 1, 1, 0);
        hs0 = hs_cnt;
        y_ready = 1'b0;
        start = 1'b1; @(negedge clk);
        start = 1'b0; @(negedge clk);
        start = 1'b1; @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!y_valid && lat < 50) begin @(negedge clk); lat++; end
        start = 1'b1; @(negedge clk);
        y_ready = 1'b1; @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("ign_one_result", 32'(hs_cnt - hs0), 32'd1);
        chk("ign_idle", 32'(busy), 32'd0);
        do_run(lat);
        chk("ign_rerun_latency", 32'(lat), 32'd5);
        chk("ign_rerun_y", 32'(y), 32'd3);
        @(negedge clk);

        // Reset during DRAIN, then a clean run
        set_mem(5, 6, 7, 9, 9, 9, 3);
        start = 1'b1; @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(y_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_mem(1, 1, 1, 2, 2, 2, -1);
        do_run(lat);
        chk("rst_rerun_latency", 32'(lat), 32'd5);
        chk("rst_rerun_y", 32'(y), 32'd5);
        @(negedge clk);

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            if (m_phase == 0 && !start && ($urandom % 4 == 0)) begin
                for (int i = 0; i < N; i++) begin
                    wm[i] = 8'($urandom);
                    xm[i] = 8'($urandom);
                end
                bias = 8'($urandom);
            end
            start   = ($urandom % 3 == 0);
            y_ready = ($urandom % 2 == 0);
            @(negedge clk);
        end
        start = 1'b0; y_ready = 1'b1;
        repeat (8) @(negedge clk);

        sweep(1'b0, 17);
        sweep(1'b1, 19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
